// File: rtl/space_inv_pkg.sv
// Shared types for the Space Invaders player blocks.
// Holds the lifecycle state enum and the counter widths.
package space_inv_pkg;

   typedef enum logic [1:0] {
      ALIVE,
      EXPLODE,
      RESPAWN,
      GAME_OVER
   } plr_state_t;

   localparam int LIVES_W = 3;
   localparam int FRAME_W = 8;
   localparam int COOL_W  = 4;

endpackage

// File: rtl/player_life_ctrl_if.sv
// Bundle between keypad/frame logic and player move/shot/draw blocks.
// master drives requests and frame timing; slave (life ctrl) drives gated outputs.
interface player_life_ctrl_if;
   import space_inv_pkg::*;

   logic               startOfFrame;
   logic               newGame;
   logic               collision;
   logic               btnRight;
   logic               btnLeft;
   logic               btnFire;
   logic               shotActive;
   logic               right;
   logic               left;
   logic               plrHit;
   logic               fireReq;
   logic               playerVisible;
   logic [LIVES_W-1:0] lives;
   logic               gameOver;

   modport master (
      output startOfFrame, newGame, collision,
      output btnRight, btnLeft, btnFire, shotActive,
      input  right, left, plrHit, fireReq,
      input  playerVisible, lives, gameOver
   );

   modport slave (
      input  startOfFrame, newGame, collision,
      input  btnRight, btnLeft, btnFire, shotActive,
      output right, left, plrHit, fireReq,
      output playerVisible, lives, gameOver
   );

endinterface

// File: rtl/frame_timer.sv
// Frame-paced counter: clear, load, count up/down on en_i, terminal compare.
// Ports: clk, reset, clr_i, ld_i, ld_val_i, en_i, tc_val_i in; cnt_o, tc_o out.
module frame_timer #(
   parameter int W  = 8,
   parameter bit UP = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   input  logic         en_i,
   input  logic [W-1:0] tc_val_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Down-counting stops at zero instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ld_i) begin
         cnt_d = ld_val_i;
      end else if (en_i) begin
         if (UP) begin
            cnt_d = cnt_q + W'(1);
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/player_life_ctrl.sv
// Player lifecycle: alive, explode, blinking respawn, game over; gates moves/fire.
// Ports: clk, reset (sync, active-high); bus = player_life_ctrl_if.slave.
module player_life_ctrl
   import space_inv_pkg::*;
#(
   parameter int unsigned INIT_LIVES     = 3,
   parameter int unsigned EXPLODE_FRAMES = 32,
   parameter int unsigned INVULN_FRAMES  = 90,
   parameter int unsigned BLINK_FRAMES   = 4,
   parameter int unsigned FIRE_COOLDOWN  = 8
) (
   input logic               clk,
   input logic               reset,
   player_life_ctrl_if.slave bus
);

   localparam int BLINK_BIT = $clog2(BLINK_FRAMES);
   localparam logic [FRAME_W-1:0] EXP_TC = FRAME_W'(EXPLODE_FRAMES - 1);
   localparam logic [FRAME_W-1:0] INV_TC = FRAME_W'(INVULN_FRAMES - 1);
   localparam logic [COOL_W-1:0]  COOL_LD = COOL_W'(FIRE_COOLDOWN);
   localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(INIT_LIVES);

   plr_state_t         state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               fire_prev_q, ng_prev_q, arm_q;
   logic               right_q, left_q, hit_q, fire_q, vis_q, over_q;
   logic               right_d, left_d, hit_d, fire_d, vis_d, over_d;

   logic [FRAME_W-1:0] fc_cnt, fc_tc_val;
   logic               fc_tc, fc_clr, frame_end, blink_nxt;
   logic [COOL_W-1:0]  cool_cnt_unused;
   logic               cool_zero;
   logic               fire_edge, ng_edge, fire_acc;
   logic               respawn_go, move_ok;

   assign frame_end = bus.startOfFrame & fc_tc;
   assign fire_edge = bus.btnFire & ~fire_prev_q;
   assign ng_edge   = bus.newGame & ~ng_prev_q;
   assign fc_tc_val = (state_q == RESPAWN) ? INV_TC : EXP_TC;

   // frameCnt only runs while a state is being timed; any transition restarts it.
   assign fc_clr = bus.newGame
                 | (state_d != state_q)
                 | (state_q == ALIVE)
                 | (state_q == GAME_OVER);

   // A collision in ALIVE takes the cycle, so a simultaneous fire edge is lost.
   assign fire_acc = fire_edge & ~bus.newGame & ~bus.shotActive & cool_zero
                   & (((state_q == ALIVE) & ~bus.collision)
                     | (state_q == RESPAWN));

   // Blink phase of the frame count the output register will be shown with.
   assign blink_nxt = 1'((fc_cnt + FRAME_W'(bus.startOfFrame)) >> BLINK_BIT);

   frame_timer #(.W(FRAME_W), .UP(1'b1)) u_frame (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (fc_clr),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .en_i     (bus.startOfFrame),
      .tc_val_i (fc_tc_val),
      .cnt_o    (fc_cnt),
      .tc_o     (fc_tc)
   );

   frame_timer #(.W(COOL_W), .UP(1'b0)) u_cool (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (bus.newGame),
      .ld_i     (fire_acc),
      .ld_val_i (COOL_LD),
      .en_i     (bus.startOfFrame),
      .tc_val_i ('0),
      .cnt_o    (cool_cnt_unused),
      .tc_o     (cool_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ALIVE;
         lives_q     <= LIVES_LD;
         fire_prev_q <= 1'b0;
         ng_prev_q   <= 1'b0;
         arm_q       <= 1'b1;
         right_q     <= 1'b0;
         left_q      <= 1'b0;
         hit_q       <= 1'b0;
         fire_q      <= 1'b0;
         vis_q       <= 1'b1;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         fire_prev_q <= bus.btnFire;
         ng_prev_q   <= bus.newGame;
         arm_q       <= 1'b0;
         right_q     <= right_d;
         left_q      <= left_d;
         hit_q       <= hit_d;
         fire_q      <= fire_d;
         vis_q       <= vis_d;
         over_q      <= over_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      respawn_go = 1'b0;
      if (bus.newGame) begin
         state_d = ALIVE;
         lives_d = LIVES_LD;
      end else begin
         unique case (state_q)
            ALIVE: begin
               if (bus.collision) begin
                  state_d = EXPLODE;
                  if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
               end
            end
            EXPLODE: begin
               if (frame_end) begin
                  if (lives_q == '0) begin
                     state_d = GAME_OVER;
                  end else begin
                     state_d    = RESPAWN;
                     respawn_go = 1'b1;
                  end
               end
            end
            RESPAWN: begin
               if (frame_end) state_d = ALIVE;
            end
            GAME_OVER: begin
               state_d = GAME_OVER;
            end
         endcase
      end
   end

   // arm_q gives the post-reset reposition; ~hit_q keeps pulses apart.
   always_comb begin
      move_ok = (state_d == ALIVE) | (state_d == RESPAWN);
      right_d = move_ok & bus.btnRight & ~bus.btnLeft;
      left_d  = move_ok & bus.btnLeft & ~bus.btnRight;
      hit_d   = (arm_q | ng_edge | respawn_go) & ~hit_q;
      fire_d  = fire_acc;
      over_d  = (state_d == GAME_OVER);
      unique case (state_d)
         ALIVE:   vis_d = 1'b1;
         RESPAWN: vis_d = (state_q != RESPAWN) | ~blink_nxt;
         default: vis_d = 1'b0;
      endcase
   end

   assign bus.right         = right_q;
   assign bus.left          = left_q;
   assign bus.plrHit        = hit_q;
   assign bus.fireReq       = fire_q;
   assign bus.playerVisible = vis_q;
   assign bus.lives         = lives_q;
   assign bus.gameOver      = over_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Scoreboard bench for player_life_ctrl against a frame-level game model.
// Driver pushes expected outputs per cycle; monitor pops and compares.
module tb_player_life_ctrl;
   import space_inv_pkg::*;

   localparam int INIT_L  = 3;
   localparam int EXP_F   = 32;
   localparam int INV_F   = 90;
   localparam int BLINK_F = 4;
   localparam int COOL_F  = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   player_life_ctrl_if bus();

   player_life_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic               right;
      logic               left;
      logic               hit;
      logic               fire;
      logic               vis;
      logic               over;
      logic [LIVES_W-1:0] lives;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   int m_lives, m_exp_left, m_resp_age, m_cool;
   bit m_over, m_resp, m_prev_fire, m_prev_ng, m_arm, m_last_hit;

   task automatic step(input bit rst, input bit sof, input bit ng,
                       input bit col, input bit br, input bit bl,
                       input bit bf, input bit sa);
      exp_t e;
      bit   alive, fe, nge, can_fire;
      @(negedge clk);
      reset            = rst;
      bus.startOfFrame = sof;
      bus.newGame      = ng;
      bus.collision    = col;
      bus.btnRight     = br;
      bus.btnLeft      = bl;
      bus.btnFire      = bf;
      bus.shotActive   = sa;
      e = '0;
      if (rst) begin
         m_lives = INIT_L; m_exp_left = 0; m_resp = 0; m_resp_age = 0;
         m_over = 0; m_cool = 0; m_prev_fire = 0; m_prev_ng = 0;
         m_arm = 1;
         e.vis   = 1'b1;
         e.lives = LIVES_W'(INIT_L);
      end else begin
         alive = !m_over && m_exp_left == 0 && !m_resp;
         fe    = bf && !m_prev_fire;
         nge   = ng && !m_prev_ng;
         if (ng) begin
            m_lives = INIT_L; m_exp_left = 0; m_resp = 0;
            m_resp_age = 0; m_over = 0; m_cool = 0;
         end else begin
            can_fire = fe && !sa && m_cool == 0 && ((alive && !col) || m_resp);
            if (sof && m_cool > 0) m_cool--;
            if (can_fire) begin
               e.fire = 1'b1;
               m_cool = COOL_F;
            end
            if (alive && col) begin
               if (m_lives > 0) m_lives--;
               m_exp_left = EXP_F;
            end else if (m_exp_left > 0) begin
               if (sof) begin
                  m_exp_left--;
                  if (m_exp_left == 0) begin
                     if (m_lives == 0) m_over = 1;
                     else begin
                        m_resp = 1; m_resp_age = 0; e.hit = 1'b1;
                     end
                  end
               end
            end else if (m_resp && sof) begin
               m_resp_age++;
               if (m_resp_age == INV_F) m_resp = 0;
            end
         end
         if (m_arm || nge) e.hit = 1'b1;
         if (m_last_hit) e.hit = 1'b0;
         m_arm = 0;
         alive   = !m_over && m_exp_left == 0 && !m_resp;
         e.right = (alive || m_resp) && br && !bl;
         e.left  = (alive || m_resp) && bl && !br;
         if (alive) e.vis = 1'b1;
         else if (m_resp) e.vis = ((m_resp_age / BLINK_F) % 2) == 0;
         else e.vis = 1'b0;
         e.over  = m_over;
         e.lives = LIVES_W'(m_lives);
         m_prev_fire = bf;
         m_prev_ng   = ng;
      end
      m_last_hit = e.hit;
      sb.push_back(e);
      cyc++;
   endtask

   always @(posedge clk) begin
      exp_t e, a;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {bus.right, bus.left, bus.plrHit, bus.fireReq,
              bus.playerVisible, bus.gameOver, bus.lives};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got r%b l%b hit%b fire%b vis%b over%b lives%0d req r%b l%b hit%b fire%b vis%b over%b lives%0d",
                     $time, a.right, a.left, a.hit, a.fire, a.vis, a.over, a.lives,
                     e.right, e.left, e.hit, e.fire, e.vis, e.over, e.lives);
         end
      end
   end

   bit r_rst, r_sof, r_col, r_br, r_bl, r_bf, r_sa;
   int ng_hold;

   initial begin
      bus.startOfFrame = 0; bus.newGame = 0; bus.collision = 0;
      bus.btnRight = 0; bus.btnLeft = 0; bus.btnFire = 0; bus.shotActive = 0;
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, (i % 4) == 3, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(0, i[0], 0, 0, 0, 0, (i % 6) < 3, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) step(0, i[0], 0, (i % 50) == 49, 1, 0, i[2], 0);
      ng_hold = 0;
      r_bf = 0; r_br = 0; r_bl = 0; r_sa = 0;
      for (int i = 0; i < 20000; i++) begin
         r_rst = ($urandom_range(0, 2999) == 0);
         r_sof = ($urandom_range(0, 2) == 0);
         r_col = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 5) == 0) r_bf = ~r_bf;
         if ($urandom_range(0, 9) == 0) r_br = ~r_br;
         if ($urandom_range(0, 9) == 0) r_bl = ~r_bl;
         if ($urandom_range(0, 19) == 0) r_sa = ~r_sa;
         if (ng_hold == 0 && $urandom_range(0, 399) == 0)
            ng_hold = $urandom_range(1, 4);
         step(r_rst, r_sof, ng_hold > 0, r_col, r_br, r_bl, r_bf, r_sa);
         if (ng_hold > 0) ng_hold--;
      end
      @(negedge clk);
      bus.newGame = 0; bus.collision = 0; bus.btnFire = 0;
      for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
      #3;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
